// File: rtl/execute_muldiv_pkg.sv
// Shared types for the iterative M-extension multiply/divide unit.
package execute_muldiv_pkg;

  localparam int WIDTH_DEFAULT = 32;

  // funct3 encoding of the M-extension operations
  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/execute_muldiv_step.sv
// One radix-2 iteration on unsigned magnitudes.
// Multiply: acc = {partial_hi, multiplier}; add operand on lsb, shift right.
// Divide:   acc = {remainder, dividend};   shift left, restoring subtract.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  // Single combinational shift-add / restoring-subtract step
  always_comb begin
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
    partial = acc[2*WIDTH-1:WIDTH-1];
    diff    = partial - {1'b0, operand};
    if (is_div) begin
      if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_next = {partial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      // carry out of the add lands in the top bit after the shift
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/execute_muldiv.sv
// Iterative multiply/divide unit for the Execute stage: one bit per cycle,
// with an IDLE->DONE shortcut for divide-by-zero and signed overflow.
module execute_muldiv
  import execute_muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_E,
  input  logic [2:0]       op_E,
  input  logic [WIDTH-1:0] srcA_E,
  input  logic [WIDTH-1:0] srcB_E,
  input  logic [4:0]       Rd_E,
  input  logic             flush_E,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       Rd_out
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  muldiv_op_t         op_q;
  logic [4:0]         rd_q;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   operand;
  logic               res_neg, rem_neg;

  logic               accept, fast, last_step;
  logic               a_signed, b_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, fast_result, final_result;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot, rem;

  assign accept    = (state == IDLE) && start_E && !flush_E;
  assign last_step = (cnt == CNT_W'(WIDTH - 1));
  assign busy      = rst_n && (accept || (state == CALC));
  assign done      = (state == DONE) && !flush_E;

  // Operand decode at accept: signedness, magnitudes, fast-path detection
  always_comb begin
    a_signed = (op_E == OP_MUL) || (op_E == OP_MULH) || (op_E == OP_MULHSU) ||
               (op_E == OP_DIV) || (op_E == OP_REM);
    b_signed = (op_E == OP_MUL) || (op_E == OP_MULH) ||
               (op_E == OP_DIV) || (op_E == OP_REM);
    a_neg    = a_signed && srcA_E[WIDTH-1];
    b_neg    = b_signed && srcB_E[WIDTH-1];
    a_mag    = a_neg ? -srcA_E : srcA_E;
    b_mag    = b_neg ? -srcB_E : srcB_E;
    fast     = op_E[2] && ((srcB_E == '0) ||
               (!op_E[0] && (srcA_E == MOST_NEG) && (srcB_E == '1)));
    if (srcB_E == '0) fast_result = op_E[1] ? srcA_E : '1;
    else              fast_result = op_E[1] ? '0 : MOST_NEG;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (op_q[2]),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  // Sign fix-up and final selection from the full-width accumulator
  always_comb begin
    prod = res_neg ? -acc_next : acc_next;
    quot = res_neg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem  = rem_neg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    case (op_q)
      OP_MUL:                     final_result = prod[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_result = prod[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:            final_result = quot;
      default:                    final_result = rem;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = fast ? DONE : CALC;
      CALC:    if (flush_E) state_next = IDLE;
               else if (last_step) state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration, and registered result/Rd_out
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every datapath register is reset too, so an abandoned op leaves no residue.
    if (!rst_n) begin
      cnt     <= '0;
      op_q    <= OP_MUL;
      rd_q    <= '0;
      acc     <= '0;
      operand <= '0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      result  <= '0;
      Rd_out  <= '0;
    end else begin
      // NOTE: non-blocking so all registers update from the same pre-edge values.
      if (accept) begin
        op_q    <= muldiv_op_t'(op_E);
        rd_q    <= Rd_E;
        cnt     <= '0;
        acc     <= {{WIDTH{1'b0}}, (op_E[2] ? a_mag : b_mag)};
        operand <= op_E[2] ? b_mag : a_mag;
        res_neg <= a_neg ^ b_neg;
        rem_neg <= a_neg;
        if (fast) begin
          result <= fast_result;
          Rd_out <= Rd_E;
        end
      end else if ((state == CALC) && !flush_E) begin
        acc <= acc_next;
        cnt <= cnt + 1'b1;
        if (last_step) begin
          result <= final_result;
          Rd_out <= rd_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_execute_muldiv.sv
// Directed bench: table of vectors plus flush and reset sequences.
module tb_execute_muldiv;
  import execute_muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_E;
  logic [2:0]  op_E;
  logic [31:0] srcA_E, srcB_E;
  logic [4:0]  Rd_E;
  logic        flush_E;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  Rd_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    muldiv_op_t  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];

  execute_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_E(start_E), .op_E(op_E),
    .srcA_E(srcA_E), .srcB_E(srcB_E), .Rd_E(Rd_E), .flush_E(flush_E),
    .busy(busy), .done(done), .result(result), .Rd_out(Rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one op, wait (bounded) for done, check latency, busy span and outputs.
  task automatic run_op(input string tag, input muldiv_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int edges;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    op_E = op; srcA_E = a; srcB_E = b; Rd_E = rd; start_E = 1'b1;
    #1 check({tag, "_busy_accept"}, 64'(busy), 64'd1);
    @(posedge clk);
    #1 start_E = 1'b0;
    edges = 0; busy_cnt = 1; seen = 1'b0;
    while (!seen && edges <= 100) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) busy_cnt++;
        @(posedge clk);
        #1 edges++;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_latency"}, 64'(edges), 64'(exp_lat));
      check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat + 1));
      check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
      check({tag, "_result"}, 64'(result), 64'(exp));
      check({tag, "_rd"}, 64'(Rd_out), 64'(rd));
      @(posedge clk);
      #1 check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
      check({tag, "_result_hold"}, 64'(result), 64'(exp));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    vecs[0]  = '{OP_MUL,    32'h00000007, 32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 32};
    vecs[1]  = '{OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 32};
    vecs[2]  = '{OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'h00000000, 32};
    vecs[3]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd4,  32'hFFFFFFFF, 32};
    vecs[4]  = '{OP_DIV,    32'hFFFFFFF9, 32'h00000002, 5'd5,  32'hFFFFFFFD, 32};
    vecs[5]  = '{OP_REM,    32'hFFFFFFF9, 32'h00000002, 5'd6,  32'hFFFFFFFF, 32};
    vecs[6]  = '{OP_DIVU,   32'd100,      32'd7,        5'd7,  32'd14,       32};
    vecs[7]  = '{OP_REMU,   32'd100,      32'd7,        5'd8,  32'd2,        32};
    vecs[8]  = '{OP_DIVU,   32'd5,        32'd0,        5'd9,  32'hFFFFFFFF, 0};
    vecs[9]  = '{OP_REMU,   32'd5,        32'd0,        5'd10, 32'd5,        0};
    vecs[10] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h80000000, 0};
    vecs[11] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000, 0};
    vecs[12] = '{OP_DIV,    32'hFFFFFFFB, 32'd0,        5'd13, 32'hFFFFFFFF, 0};
    vecs[13] = '{OP_REM,    32'hFFFFFFFB, 32'd0,        5'd14, 32'hFFFFFFFB, 0};
    vecs[14] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, 32};
    vecs[15] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 5'd16, 32'd1,        32};
    vecs[16] = '{OP_MUL,    32'h80000000, 32'hFFFFFFFF, 5'd17, 32'h80000000, 32};
    vecs[17] = '{OP_MULHU,  32'h80000000, 32'd2,        5'd18, 32'd1,        32};
    vecs[18] = '{OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        32};
    vecs[19] = '{OP_MUL,    32'h12345678, 32'h00000010, 5'd31, 32'h23456780, 32};

    // Reset state, with start_E asserted to show busy is masked
    rst_n = 1'b0; start_E = 1'b1; flush_E = 1'b0;
    op_E = 3'd0; srcA_E = '0; srcB_E = '0; Rd_E = '0;
    #3;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    check("reset_rd", 64'(Rd_out), 64'd0);
    start_E = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // Flush on the 10th CALC cycle: no done, result untouched, restart works
    @(negedge clk);
    op_E = OP_MUL; srcA_E = 32'd3; srcB_E = 32'd5; Rd_E = 5'd9; start_E = 1'b1;
    @(posedge clk);
    #1 start_E = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("flush_busy_before", 64'(busy), 64'd1);
    flush_E = 1'b1;
    #1 check("flush_done_masked", 64'(done), 64'd0);
    @(posedge clk);
    #1 flush_E = 1'b0;
    check("flush_busy_after", 64'(busy), 64'd0);
    check("flush_done_after", 64'(done), 64'd0);
    check("flush_result_kept", 64'(result), 64'(vecs[NVEC-1].exp));
    check("flush_rd_kept", 64'(Rd_out), 64'(vecs[NVEC-1].rd));
    run_op("after_flush", OP_DIVU, 32'd1000, 32'd10, 5'd17, 32'd100, 32);

    // Reset pulse mid-CALC: immediate clear, op abandoned
    @(negedge clk);
    op_E = OP_MULHU; srcA_E = 32'hFFFFFFFF; srcB_E = 32'hFFFFFFFF; Rd_E = 5'd21; start_E = 1'b1;
    @(posedge clk);
    #1 start_E = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0; start_E = 1'b1;
    #1;
    check("midreset_result", 64'(result), 64'd0);
    check("midreset_rd", 64'(Rd_out), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1; start_E = 1'b0;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1 if (done) done_seen++;
    end
    check("midreset_no_done", 64'(done_seen), 64'd0);
    check("midreset_result_after", 64'(result), 64'd0);

    run_op("b2b0", OP_REMU, 32'd100, 32'd7, 5'd22, 32'd2, 32);
    run_op("b2b1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd23, 32'h80000000, 0);
    run_op("b2b2", OP_MULHSU, 32'hFFFFFFFF, 32'h00000002, 5'd24, 32'hFFFFFFFF, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
